// File: rtl/x_srl_fifo_pkg.sv
// Shared sizing constants and the accept-operation encoding for x_srl_fifo.
package x_srl_fifo_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  // Encoded as {wr_ok, rd_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    return fifo_op_e'({wr_ok, rd_ok});
  endfunction

endpackage

// File: rtl/x_srl_fifo_store.sv
// WIDTH parallel 16-tap addressable shift registers sharing CE and read address.
// Storage is intentionally not reset; INIT only sets the power-up contents.
module x_srl_fifo_store
  import x_srl_fifo_pkg::*;
#(
  parameter int                       WIDTH = 8,
  parameter logic [WIDTH*DEPTH-1:0]   INIT  = '0
) (
  input  logic              CLK,
  input  logic              CE,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic [DEPTH-1:0] sr_q = INIT[i*DEPTH +: DEPTH];
    logic [DEPTH-1:0] sr_d;

    // next contents of this slice: shift D in at tap 0 when enabled
    always_comb begin
      if (CE) begin
        sr_d = {sr_q[DEPTH-2:0], D[i]};
      end else begin
        sr_d = sr_q;
      end
    end

    // slice storage register
    always_ff @(posedge CLK) begin
      sr_q <= sr_d;
    end

    assign Q[i] = sr_q[A];
  end

endmodule

// File: rtl/x_srl_fifo.sv
// 16-deep first-word-fall-through FIFO over SRL-style storage: counter, address, flags.
// Optional ALMOST_FULL/ALMOST_EMPTY ports are enabled by defining X_SRL_FIFO_ALMOST_EN.
module x_srl_fifo
  import x_srl_fifo_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef X_SRL_FIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
`ifdef X_SRL_FIFO_ALMOST_EN
  ,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
`endif
);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              empty_s, full_s, rd_ok_s, wr_ok_s, store_ce_s;
  logic [WIDTH-1:0]  store_q_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);
  assign rd_ok_s = RD_EN & ~empty_s;
  assign wr_ok_s = WR_EN & (~full_s | rd_ok_s);
  // Reset wins over a same-edge write so nothing is shifted in on that edge
  assign store_ce_s = wr_ok_s & ~RST;

  x_srl_fifo_store #(
    .WIDTH (WIDTH)
  ) u_store (
    .CLK (CLK),
    .CE  (store_ce_s),
    .A   (addr_q),
    .D   (DIN),
    .Q   (store_q_s)
  );

  // next counter, read address and error pulses
  always_comb begin
    count_d     = count_q;
    addr_d      = addr_q;
    overflow_d  = WR_EN & ~wr_ok_s;
    underflow_d = RD_EN & empty_s;
    case (decode_op(wr_ok_s, rd_ok_s))
      OP_PUSH: begin
        count_d = count_q + CNT_ONE;
        if (empty_s) begin
          addr_d = ADDR_ZERO;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      OP_POP: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          addr_d = ADDR_ZERO;
        end else begin
          addr_d = addr_q - ADDR_ONE;
        end
      end
      OP_BOTH: begin
        count_d = count_q;
        addr_d  = addr_q;
      end
      default: begin
        count_d = count_q;
        addr_d  = addr_q;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q     <= CNT_ZERO;
      addr_q      <= ADDR_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign DOUT      = empty_s ? {WIDTH{1'b0}} : store_q_s;
  assign FULL      = full_s;
  assign EMPTY     = empty_s;
  assign COUNT     = count_q;
  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;

`ifdef X_SRL_FIFO_ALMOST_EN
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_LEVEL);
  assign ALMOST_FULL  = (count_q >= AF_LVL);
  assign ALMOST_EMPTY = (count_q <= AE_LVL);
`endif

endmodule
